multi_gate_reducer: RTL and testbench
=====================================

Name: multi_gate_reducer

Overview:
- Parametrised, clocked successor to the team's fixed 3-input gate primitives.
- Each accepted beat is N_IN lanes of WIDTH bits; the block reduces the lanes bitwise with a selectable gate (AND/OR/XOR and their inversions).
- It folds successive beats of a frame into one result and returns that result over a valid/ready handshake.
- It sits between stimulus/capture logic and downstream consumers in the lab datapath.

Parameters:
- N_IN, 3, number of input lanes (≥2).
- WIDTH, 1, bits per lane and width of the result.
- MAX_BEATS, 8, maximum beats per frame before a forced close (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N_IN*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- op  input  3  gate select: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 11x reserved.
- in_valid  input  1  beat offered.
- in_last  input  1  final beat of the frame; qualified by in_valid.
- in_ready  output  1  block accepts a beat this cycle.
- out_data  output  WIDTH  frame result.
- out_count  output  $clog2(MAX_BEATS+1)  number of beats folded into the frame.
- out_trunc  output  1  frame was closed by MAX_BEATS, not by in_last.
- out_err  output  1  reserved op was latched for the frame.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.

Behaviour:
- Reset (async, any state): state=IDLE, accumulator=0, beat count=0, out_data=0, out_count=0, out_trunc=0, out_err=0, out_valid=0. in_ready=1 once rst deasserts.
- A beat is accepted when in_valid && in_ready.
- Per beat, r = bitwise reduction across the N_IN lanes using the base gate: AND for 000/011, OR for 001/100, XOR for 010/101.
- op is latched on the first beat of a frame (IDLE accept). op changes mid-frame are ignored.
- States:
  - IDLE (in_ready=1): on accept, acc<=r, cnt<=1. If in_last or MAX_BEATS==1, go to HOLD; else go to ACCUM.
  - ACCUM (in_ready=1): on accept, acc<=acc base-gate r, cnt<=cnt+1. If in_last, go to HOLD with trunc=0. Else if cnt+1==MAX_BEATS, go to HOLD with trunc=1. No accept: hold.
  - HOLD (in_ready=0, out_valid=1): outputs stable.
    - When out_ready=1, go to IDLE; out_valid drops the next cycle.
    - in_ready returns the cycle after the handshake; there is no same-cycle bypass.
- Output mapping, registered on entry to HOLD:
  - out_data = acc, inverted for ops 011/100/101.
  - Latency: the result is valid on the cycle after the closing beat.
- Reserved op (11x) latched: beats are still consumed and counted. In HOLD, out_data=0 and out_err=1.
- out_count saturates at MAX_BEATS and never wraps.
- in_last on a beat that also reaches MAX_BEATS: in_last wins, trunc=0.
- Reset mid-frame or in HOLD: the partial frame is discarded and no output is produced.
- Holding out_ready=1 in IDLE/ACCUM has no effect.
- in_data/in_last are don't-care when in_valid=0.

Test Plan:
- N_IN=3, WIDTH=4, op=001, one beat {4'h1,4'h2,4'h4} with in_last -> next cycle out_valid=1, out_data=4'h7, out_count=1, trunc=0, err=0.
- op=000, beats {F,F,3} then {F,7,F}+last -> out_data=4'h3, out_count=2. Repeat with op=011 -> out_data=4'hC.
- op=010, 8 beats each {1,0,0}, no in_last, MAX_BEATS=8 -> forced close after beat 8, out_data=4'h0, out_count=8, trunc=1, in_ready=0 while out_ready=0.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> outputs unchanged, further in_valid beats are not accepted. out_ready=1 -> out_valid low and in_ready high the following cycle.
- op=110 for a 2-beat frame -> out_err=1, out_data=0, out_count=2. Next frame with op=001 -> err=0.
- Assert rst mid-ACCUM after 3 beats -> all outputs 0 immediately, in_ready=1. A new 1-beat frame returns out_count=1.

Source files
------------

// File: rtl/multi_gate_reducer.sv
// Purpose: reduces N_IN lanes per beat with a selectable gate and folds all beats of a frame into one result.
// Latency: result is valid the cycle after the closing beat (in_last or MAX_BEATS reached).
// Backpressure: holds the result while out_ready=0; in_ready stays low until the cycle after the handshake.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_data[N_IN*WIDTH] lane k at bits [k*WIDTH +: WIDTH]
//   op[3]               000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 11x reserved
//   in_valid/in_ready   beat handshake, in_last marks the final beat of a frame
//   out_data/out_count  frame result and number of beats folded into it
//   out_trunc/out_err   closed by MAX_BEATS / reserved op latched
//   out_valid/out_ready result handshake
module multi_gate_reducer #(
  parameter int N_IN      = 3,
  parameter int WIDTH     = 1,
  parameter int MAX_BEATS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_IN*WIDTH-1:0]          in_data,
  input  logic [2:0]                     op,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [$clog2(MAX_BEATS+1)-1:0] out_count,
  output logic                           out_trunc,
  output logic                           out_err,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    G_AND = 2'd0,
    G_OR  = 2'd1,
    G_XOR = 2'd2
  } gate_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;

  logic              accept;
  logic              close;
  logic [2:0]        op_eff;
  gate_t             gate;
  logic [WIDTH-1:0]  lane_red;
  logic [WIDTH-1:0]  acc_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              rsvd;
  logic              invert;
  logic [WIDTH-1:0]  res_data;

  // Inverting ops share the datapath of their base gate; inversion is applied at the output.
  function automatic gate_t base_of(input logic [2:0] o);
    gate_t g;
    case (o)
      3'b001, 3'b100: g = G_OR;
      3'b010, 3'b101: g = G_XOR;
      default:        g = G_AND;
    endcase
    return g;
  endfunction

  function automatic logic [WIDTH-1:0] combine(input gate_t g,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] y;
    case (g)
      G_OR:    y = a | b;
      G_XOR:   y = a ^ b;
      default: y = a & b;
    endcase
    return y;
  endfunction

  // ---------------------------------------------------------------- datapath comb
  always_comb begin
    accept   = in_valid && in_ready;
    // The first beat uses the live op; later beats use the op latched with it.
    op_eff   = (state == ST_IDLE) ? op : op_q;
    gate     = base_of(op_eff);
    rsvd     = op_eff[2] & op_eff[1];
    invert   = (op_eff == 3'b011) || (op_eff == 3'b100) || (op_eff == 3'b101);

    lane_red = in_data[WIDTH-1:0];
    for (int k = 1; k < N_IN; k++) begin
      lane_red = combine(gate, lane_red, in_data[k*WIDTH +: WIDTH]);
    end

    if (state == ST_IDLE) begin
      acc_nxt = lane_red;
      cnt_nxt = CNT_W'(1);
    end else begin
      acc_nxt = combine(gate, acc, lane_red);
      cnt_nxt = cnt + CNT_W'(1);
    end

    // Forced close at MAX_BEATS keeps the count from ever passing MAX_BEATS.
    close    = accept && (in_last || (cnt_nxt == MAX_CNT));
    res_data = rsvd ? '0 : (invert ? ~acc_nxt : acc_nxt);
  end

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_ACCUM: begin
        if (close) begin
          state_nxt = ST_HOLD;
        end else if (accept) begin
          state_nxt = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE, ST_ACCUM: in_ready  = 1'b1;
      ST_HOLD:           out_valid = 1'b1;
      default:           in_ready  = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- accumulator and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      op_q      <= 3'b000;
      out_data  <= '0;
      out_count <= '0;
      out_trunc <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      if (accept) begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
        if (state == ST_IDLE) begin
          op_q <= op;
        end
      end
      // Result registers only change on entry to HOLD, so they stay stable under backpressure.
      if (close) begin
        out_data  <= res_data;
        out_count <= cnt_nxt;
        out_trunc <= ~in_last;
        out_err   <= rsvd;
      end
    end
  end

endmodule

// File: tb/tb_multi_gate_reducer.sv
module tb_multi_gate_reducer;

  localparam int N_IN      = 3;
  localparam int WIDTH     = 4;
  localparam int MAX_BEATS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] in_data;
  logic [2:0]  op;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [3:0]  out_data;
  logic [3:0]  out_count;
  logic        out_trunc;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  logic [11:0] frame_q[$];

  multi_gate_reducer #(.N_IN(N_IN), .WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .op(op), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_count(out_count),
    .out_trunc(out_trunc), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: fold every lane of every beat with the base gate, then apply inversion / reserved rule.
  function automatic logic [3:0] model_data(input logic [2:0] o);
    logic [3:0] v;
    logic [3:0] lane;
    logic [11:0] beat;
    v = (o == 3'd0 || o == 3'd3) ? 4'hF : 4'h0;
    for (int i = 0; i < frame_q.size(); i++) begin
      beat = frame_q[i];
      for (int k = 0; k < N_IN; k++) begin
        lane = beat[k*4 +: 4];
        case (o)
          3'd0, 3'd3: v = v & lane;
          3'd1, 3'd4: v = v | lane;
          3'd2, 3'd5: v = v ^ lane;
          default:    v = v;
        endcase
      end
    end
    if (o >= 3'd6)      return 4'h0;
    else if (o >= 3'd3) return ~v;
    else                return v;
  endfunction

  task automatic send_beat(input logic [11:0] d, input logic [2:0] o, input logic l);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_beat_timeout in_ready got %0b want 1", in_ready);
    end
    in_valid = 1'b1; in_data = d; op = o; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 12'($urandom); in_last = 1'($urandom);
  endtask

  // Sends frame_q; later beats carry a random op (must be ignored) and random out_ready.
  task automatic drive_frame(input logic [2:0] fop, input bit use_last, input bit gaps);
    int n;
    n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        repeat ($urandom_range(0, 2)) begin
          out_ready = 1'($urandom);
          @(posedge clk); #1;
        end
      end
      out_ready = (i < n - 1) ? 1'($urandom) : 1'b0;
      send_beat(frame_q[i], (i == 0) ? fop : 3'($urandom), use_last && (i == n - 1));
      out_ready = 1'b0;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; op = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
    checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", out_count); end
    checks++; if ({out_trunc, out_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {out_trunc, out_err}); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_or_single();
    frame_q = {};
    frame_q.push_back({4'h4, 4'h2, 4'h1});
    drive_frame(3'b001, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL or_valid got %0b want 1", out_valid); end
    checks++; if (out_data !== 4'h7) begin errors++; $display("FAIL or_data got %h want 7", out_data); end
    checks++; if (out_count !== 4'd1) begin errors++; $display("FAIL or_count got %0d want 1", out_count); end
    checks++; if ({out_trunc, out_err} !== 2'b00) begin errors++; $display("FAIL or_flags got %b want 00", {out_trunc, out_err}); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL or_ready_hold got %0b want 0", in_ready); end
    release_out();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL or_valid_drop got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL or_ready_back got %0b want 1", in_ready); end
  endtask

  task automatic test_and_nand();
    logic [2:0] ops[2];
    logic [3:0] want[2];
    ops[0] = 3'b000; ops[1] = 3'b011;
    want[0] = 4'h3;  want[1] = 4'hC;
    for (int t = 0; t < 2; t++) begin
      frame_q = {};
      frame_q.push_back({4'hF, 4'hF, 4'h3});
      frame_q.push_back({4'hF, 4'h7, 4'hF});
      drive_frame(ops[t], 1'b1, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL and_valid op=%0d got %0b want 1", ops[t], out_valid); end
      checks++; if (out_data !== want[t]) begin errors++; $display("FAIL and_data op=%0d got %h want %h", ops[t], out_data, want[t]); end
      checks++; if (out_count !== 4'd2) begin errors++; $display("FAIL and_count op=%0d got %0d want 2", ops[t], out_count); end
      release_out();
    end
  endtask

  task automatic test_forced_close();
    frame_q = {};
    repeat (MAX_BEATS) frame_q.push_back({4'h0, 4'h0, 4'h1});
    drive_frame(3'b010, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL xor_valid got %0b want 1", out_valid); end
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL xor_data got %h want 0", out_data); end
    checks++; if (out_count !== 4'd8) begin errors++; $display("FAIL xor_count got %0d want 8", out_count); end
    checks++; if (out_trunc !== 1'b1) begin errors++; $display("FAIL xor_trunc got %0b want 1", out_trunc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL xor_ready got %0b want 0", in_ready); end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_d;
    frame_q = {};
    frame_q.push_back(12'($urandom));
    frame_q.push_back(12'($urandom));
    drive_frame(3'b100, 1'b1, 1'b0);
    exp_d = model_data(3'b100);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = 12'($urandom); in_last = 1'b1; op = 3'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_d || out_count !== 4'd2 || out_trunc !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got v=%0b r=%0b d=%h c=%0d t=%0b want v=1 r=0 d=%h c=2 t=0",
                 c, out_valid, in_ready, out_data, out_count, out_trunc, exp_d);
      end
    end
    in_valid = 1'b0;
    release_out();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v=%0b r=%0b want v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_reserved();
    frame_q = {};
    frame_q.push_back(12'($urandom));
    frame_q.push_back(12'($urandom));
    drive_frame(3'b110, 1'b1, 1'b0);
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL rsvd_err got %0b want 1", out_err); end
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL rsvd_data got %h want 0", out_data); end
    checks++; if (out_count !== 4'd2) begin errors++; $display("FAIL rsvd_count got %0d want 2", out_count); end
    release_out();
    frame_q = {};
    frame_q.push_back({4'h4, 4'h2, 4'h1});
    drive_frame(3'b001, 1'b1, 1'b0);
    checks++; if (out_err !== 1'b0 || out_data !== 4'h7) begin errors++; $display("FAIL rsvd_next got err=%0b d=%h want err=0 d=7", out_err, out_data); end
    release_out();
  endtask

  task automatic test_reset_mid();
    frame_q = {};
    repeat (3) frame_q.push_back({4'h1, 4'h3, 4'h7});
    drive_frame(3'b001, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_count !== 4'd0 || out_trunc !== 1'b0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_outs got v=%0b d=%h c=%0d t=%0b e=%0b r=%0b want all 0 and r=1",
               out_valid, out_data, out_count, out_trunc, out_err, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    frame_q = {};
    frame_q.push_back({4'h8, 4'h0, 4'h1});
    drive_frame(3'b001, 1'b1, 1'b0);
    checks++; if (out_count !== 4'd1 || out_data !== 4'h9) begin errors++; $display("FAIL rstmid_new got c=%0d d=%h want c=1 d=9", out_count, out_data); end
    release_out();
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      frame_q = {};
      repeat (MAX_BEATS) frame_q.push_back(12'($urandom));
      drive_frame(3'b010, 1'b1, 1'b0);
      checks++;
      if (out_count !== 4'd8 || out_trunc !== 1'b0 || out_data !== model_data(3'b010)) begin
        errors++;
        $display("FAIL b2b_last_at_max f=%0d got c=%0d t=%0b d=%h want c=8 t=0 d=%h",
                 f, out_count, out_trunc, out_data, model_data(3'b010));
      end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [2:0] o;
    int n;
    bit use_last;
    for (int f = 0; f < 40; f++) begin
      o = 3'($urandom);
      use_last = 1'($urandom_range(0, 3) != 0);
      n = use_last ? $urandom_range(1, MAX_BEATS) : MAX_BEATS;
      frame_q = {};
      repeat (n) frame_q.push_back(12'($urandom));
      drive_frame(o, use_last, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== model_data(o) || out_count !== 4'(n) ||
          out_trunc !== !use_last || out_err !== (o >= 3'd6)) begin
        errors++;
        $display("FAIL rand f=%0d op=%0d got v=%0b d=%h c=%0d t=%0b e=%0b want v=1 d=%h c=%0d t=%0b e=%0b",
                 f, o, out_valid, out_data, out_count, out_trunc, out_err,
                 model_data(o), n, !use_last, (o >= 3'd6));
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_or_single();
    test_and_nand();
    test_forced_close();
    test_backpressure();
    test_reserved();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
